// File: rtl/pc_fetch_unit_if.sv
// ID/hazard-side redirect bus and IF-side fetch outputs of the PC fetch unit.
// master: the ID stage / hazard unit / instruction memory side.
// slave: the PC fetch unit itself.
interface pc_fetch_unit_if #(
  parameter int unsigned ISA_WIDTH = 32
);
  logic                 no_op;
  logic                 mem_ready;
  logic [ISA_WIDTH-1:0] id_pc;
  logic                 pc_offset;
  logic [ISA_WIDTH-1:0] pc_offset_value;
  logic                 pc_overload;
  logic [ISA_WIDTH-1:0] pc_overload_value;
  logic [ISA_WIDTH-1:0] if_pc;
  logic [ISA_WIDTH-1:0] if_pc_4;
  logic                 fetch_valid;
  logic                 flush_if_id;
  logic                 redirect_pending;
  logic                 misalign_err;

  modport master (
    output no_op, mem_ready, id_pc, pc_offset, pc_offset_value, pc_overload,
           pc_overload_value,
    input  if_pc, if_pc_4, fetch_valid, flush_if_id, redirect_pending, misalign_err
  );

  modport slave (
    input  no_op, mem_ready, id_pc, pc_offset, pc_offset_value, pc_overload,
           pc_overload_value,
    output if_pc, if_pc_4, fetch_valid, flush_if_id, redirect_pending, misalign_err
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter: sequential fetch, ID-stage branch/jump redirects,
// hazard stalls and instruction-memory wait states. A redirect that meets a
// busy memory is parked in a pending register so it is applied exactly once.
module pc_fetch_unit #(
  parameter int unsigned          ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] PC_RESET  = '0
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_unit_if.slave  bus
);

  typedef enum logic [0:0] {StRun, StPending} state_e;

  localparam logic [ISA_WIDTH-1:0] PcStep = ISA_WIDTH'(4);

  state_e               state_q, state_d;
  logic [ISA_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [ISA_WIDTH-1:0] pending_q, pending_d;
  logic                 misalign_q, misalign_d;
  logic                 first_q;

  logic                 redirect;
  logic [ISA_WIDTH-1:0] target;

  // Redirect target: jumps take priority over branches; branch offset is in words.
  always_comb begin
    redirect = bus.pc_overload | bus.pc_offset;
    if (bus.pc_overload) begin
      target = {bus.pc_overload_value[ISA_WIDTH-1:2], 2'b00};
    end else begin
      target = bus.id_pc + PcStep + (bus.pc_offset_value << 2);
    end
  end

  // State and datapath registers; first_q marks the cycle right after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      if_pc_q    <= PC_RESET;
      pending_q  <= '0;
      misalign_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      if_pc_q    <= if_pc_d;
      pending_q  <= pending_d;
      misalign_q <= misalign_d;
      first_q    <= 1'b0;
    end
  end

  // Next-state: stalls hold everything in RUN; PENDING ignores stall and redirects.
  always_comb begin
    state_d    = state_q;
    if_pc_d    = if_pc_q;
    pending_d  = pending_q;
    misalign_d = misalign_q;
    unique case (state_q)
      StRun: begin
        if (!bus.no_op) begin
          if (redirect) begin
            if (bus.mem_ready) begin
              if_pc_d = target;
            end else begin
              pending_d = target;
              state_d   = StPending;
            end
            if (bus.pc_overload && (bus.pc_overload_value[1:0] != 2'b00)) begin
              misalign_d = 1'b1;
            end
          end else if (bus.mem_ready) begin
            if_pc_d = if_pc_q + PcStep;
          end
        end
      end
      StPending: begin
        if (bus.mem_ready) begin
          if_pc_d = pending_q;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs: flush on an accepted redirect and for every cycle spent in PENDING.
  always_comb begin
    bus.if_pc            = if_pc_q;
    bus.if_pc_4          = if_pc_q + PcStep;
    bus.misalign_err     = misalign_q;
    bus.redirect_pending = (state_q == StPending);
    bus.flush_if_id      = 1'b0;
    bus.fetch_valid      = 1'b0;
    unique case (state_q)
      StRun: begin
        bus.flush_if_id = ~bus.no_op & redirect;
        bus.fetch_valid = ~first_q & bus.mem_ready & ~bus.no_op;
      end
      StPending: begin
        bus.flush_if_id = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table walked one cycle per entry,
// followed by a hand-written reset-during-PENDING sequence.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_fetch_unit_if #(.ISA_WIDTH(32)) bus ();

  pc_fetch_unit #(
    .ISA_WIDTH(32),
    .PC_RESET (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        no_op;
    logic        mem_ready;
    logic [31:0] id_pc;
    logic        pc_offset;
    logic [31:0] off_val;
    logic        pc_overload;
    logic [31:0] ov_val;
    logic [31:0] exp_pc;
    logic        exp_fv;
    logic        exp_flush;
    logic        exp_pend;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic nop, input logic mr, input logic [31:0] idpc,
                              input logic off, input logic [31:0] offv, input logic ov,
                              input logic [31:0] ovv, input logic [31:0] pc, input logic fv,
                              input logic fl, input logic pd, input logic mi);
    vec_t v;
    v.no_op = nop; v.mem_ready = mr; v.id_pc = idpc; v.pc_offset = off; v.off_val = offv;
    v.pc_overload = ov; v.ov_val = ovv; v.exp_pc = pc; v.exp_fv = fv; v.exp_flush = fl;
    v.exp_pend = pd; v.exp_mis = mi;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.no_op             = v.no_op;
    bus.mem_ready         = v.mem_ready;
    bus.id_pc             = v.id_pc;
    bus.pc_offset         = v.pc_offset;
    bus.pc_offset_value   = v.off_val;
    bus.pc_overload       = v.pc_overload;
    bus.pc_overload_value = v.ov_val;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] pc, input logic fv,
                               input logic fl, input logic pd, input logic mi);
    chk({tag, " if_pc"}, bus.if_pc, pc);
    chk({tag, " if_pc_4"}, bus.if_pc_4, pc + 32'd4);
    chk({tag, " fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
    chk({tag, " flush_if_id"}, {31'd0, bus.flush_if_id}, {31'd0, fl});
    chk({tag, " redirect_pending"}, {31'd0, bus.redirect_pending}, {31'd0, pd});
    chk({tag, " misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, mi});
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    idle = '{no_op: 1'b0, mem_ready: 1'b1, id_pc: 32'd0, pc_offset: 1'b0, off_val: 32'd0,
             pc_overload: 1'b0, ov_val: 32'd0, exp_pc: 32'd0, exp_fv: 1'b0,
             exp_flush: 1'b0, exp_pend: 1'b0, exp_mis: 1'b0};

    //  nop mr  id_pc        off offv          ov  ovv           exp_pc       fv fl pd mi
    // Sequential fetch out of reset; first cycle is not a valid fetch.
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h0,       0, 0, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h4,       1, 0, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h8,       1, 0, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'hC,       1, 0, 0, 0);
    // Memory wait then hazard stall: PC holds.
    add(0, 0, 32'h0,       0, 32'h0,        0, 32'h0,        32'h10,      0, 0, 0, 0);
    add(1, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h10,      0, 0, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h10,      1, 0, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h14,      1, 0, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h18,      1, 0, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h1C,      1, 0, 0, 0);
    // Backward branch: 0x1C + 4 + (-2 << 2) = 0x18.
    add(0, 1, 32'h1C,      1, 32'hFFFF_FFFE, 0, 32'h0,       32'h20,      1, 1, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h18,      1, 0, 0, 0);
    // Jump beats branch; misaligned target sets sticky error.
    add(0, 1, 32'h18,      1, 32'h5,        1, 32'h0040_0103, 32'h1C,     1, 1, 0, 0);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h0040_0100, 1, 0, 0, 1);
    // Stalled branch for 3 cycles, then applied once: 0x400100 + 4 + 16.
    add(1, 1, 32'h0040_0100, 1, 32'h4,      0, 32'h0,        32'h0040_0104, 0, 0, 0, 1);
    add(1, 1, 32'h0040_0100, 1, 32'h4,      0, 32'h0,        32'h0040_0104, 0, 0, 0, 1);
    add(1, 1, 32'h0040_0100, 1, 32'h4,      0, 32'h0,        32'h0040_0104, 0, 0, 0, 1);
    add(0, 1, 32'h0040_0100, 1, 32'h4,      0, 32'h0,        32'h0040_0104, 1, 1, 0, 1);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h0040_0114, 1, 0, 0, 1);
    // Jump to 0x100 while memory busy; 0x200 during PENDING must be ignored.
    add(0, 0, 32'h0,       0, 32'h0,        1, 32'h100,      32'h0040_0118, 0, 1, 0, 1);
    add(0, 0, 32'h0,       0, 32'h0,        1, 32'h200,      32'h0040_0118, 0, 1, 1, 1);
    add(1, 1, 32'h0,       0, 32'h0,        1, 32'h200,      32'h0040_0118, 0, 1, 1, 1);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h100,     1, 0, 0, 1);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h104,     1, 0, 0, 1);
    // PC wrap at the top of the address space.
    add(0, 1, 32'h0,       0, 32'h0,        1, 32'hFFFF_FFFC, 32'h108,    1, 1, 0, 1);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 1, 0, 0, 1);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h0,       1, 0, 0, 1);
    add(0, 1, 32'h0,       0, 32'h0,        0, 32'h0,        32'h4,       1, 0, 0, 1);

    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_fv,
                    vecs[i].exp_flush, vecs[i].exp_pend, vecs[i].exp_mis);
      @(posedge clk);
      #1;
    end

    // Enter PENDING with a jump to 0x300, then pulse reset mid-PENDING.
    bus.pc_overload       = 1'b1;
    bus.pc_overload_value = 32'h300;
    bus.mem_ready         = 1'b0;
    @(posedge clk);
    #1;
    bus.pc_overload = 1'b0;
    @(negedge clk);
    check_outputs("pend_enter", 32'h8, 1'b0, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("pend_reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check_outputs("post_reset0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_outputs("post_reset1", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
